// File: rtl/sr_cmd_driver.sv
// Command driver for a downstream master-slave SR latch: pulses S or R per command,
// waits for the latch to settle, then checks the Q feedback against the expected value.
module sr_cmd_driver #(
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  input  logic [1:0] CMD_OP,
  output logic       CMD_READY,
  input  logic       Q_FB,
  output logic       S,
  output logic       R,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] CMD_CNT
);

  localparam logic [3:0] HoldLast   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSettle, StCheck} state_e;

  state_e     r_state, w_state_d;
  logic [3:0] r_cnt, w_cnt_d;
  logic       r_exp, w_exp_d;
  logic       r_s, r_r, r_done, r_err;
  logic [7:0] r_cmd_cnt;
  logic       w_accept;
  logic       w_s_d, w_r_d, w_done_d, w_err_d;
  logic [7:0] w_cmd_cnt_d;

  assign w_accept = CMD_VALID && CMD_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_exp     <= 1'b0;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cmd_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_exp     <= w_exp_d;
      r_s       <= w_s_d;
      r_r       <= w_r_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
      r_cmd_cnt <= w_cmd_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_exp_d   = r_exp;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_cnt_d = 4'd0;
          unique case (CMD_OP)
            2'b00: begin w_exp_d = Q_FB;  w_state_d = StCheck; end
            2'b01: begin w_exp_d = 1'b1;  w_state_d = StDrive; end
            2'b10: begin w_exp_d = 1'b0;  w_state_d = StDrive; end
            2'b11: begin w_exp_d = ~Q_FB; w_state_d = StDrive; end
            default: w_state_d = StIdle;
          endcase
        end
      end
      StDrive: begin
        if (r_cnt == HoldLast) begin
          w_cnt_d   = 4'd0;
          w_state_d = StSettle;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      StSettle: begin
        if (r_cnt == SettleLast) begin
          w_cnt_d   = 4'd0;
          w_state_d = StCheck;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      StCheck: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // S/R/DONE are registered from the next state so they line up with the state they describe;
  // S and R are qualified by complementary values of w_exp_d, so they cannot both be high.
  always_comb begin
    CMD_READY   = (r_state == StIdle) && !RST;
    BUSY        = (r_state != StIdle);
    w_s_d       = (w_state_d == StDrive) && w_exp_d;
    w_r_d       = (w_state_d == StDrive) && !w_exp_d;
    w_done_d    = (w_state_d == StCheck);
    w_err_d     = r_err || ((r_state == StCheck) && (Q_FB != r_exp));
    w_cmd_cnt_d = (r_state == StCheck) ? r_cmd_cnt + 8'd1 : r_cmd_cnt;
  end

  assign S       = r_s;
  assign R       = r_r;
  assign DONE    = r_done;
  assign ERR     = r_err;
  assign CMD_CNT = r_cmd_cnt;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Randomized bench for sr_cmd_driver: two instances (default timing and 1/1 timing) share
// stimulus and are compared every cycle against a per-command timeline model.
module tb_sr_cmd_driver;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic [1:0] CMD_OP;
  logic       qfb   [2];
  logic       rdy_o [2];
  logic       s_o   [2];
  logic       r_o   [2];
  logic       busy_o[2];
  logic       done_o[2];
  logic       err_o [2];
  logic [7:0] cnt_o [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a command is "accept cycle + elapsed k"; outputs follow from k alone.
  int m_active[2];
  int m_k     [2];
  bit m_val   [2];
  bit m_drv   [2];
  bit m_err   [2];
  int m_cnt   [2];
  int m_total [2];

  // Latch environment
  bit q_lat[2];
  bit stuck_en;
  bit stuck_val;

  always #5 CLK = ~CLK;

  sr_cmd_driver #(.HOLD_CYC(2), .SETTLE_CYC(2)) u_dut0 (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP), .CMD_READY(rdy_o[0]),
    .Q_FB(qfb[0]), .S(s_o[0]), .R(r_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0]),
    .ERR(err_o[0]), .CMD_CNT(cnt_o[0])
  );

  sr_cmd_driver #(.HOLD_CYC(1), .SETTLE_CYC(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP), .CMD_READY(rdy_o[1]),
    .Q_FB(qfb[1]), .S(s_o[1]), .R(r_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1]),
    .ERR(err_o[1]), .CMD_CNT(cnt_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int hold_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int len_of(input int i);
    return m_drv[i] ? hold_of(i) + ((i == 0) ? 2 : 1) + 1 : 1;
  endfunction

  task automatic model_edge(input int i, input bit rst, input bit valid, input logic [1:0] op,
                            input bit q);
    if (rst) begin
      m_active[i] = 0;
      m_err[i]    = 1'b0;
      m_cnt[i]    = 0;
    end else if (m_active[i] != 0) begin
      if (m_k[i] == len_of(i)) begin
        if (q != m_val[i]) m_err[i] = 1'b1;
        m_cnt[i]    = (m_cnt[i] + 1) % 256;
        m_total[i]  = m_total[i] + 1;
        m_active[i] = 0;
      end else begin
        m_k[i] = m_k[i] + 1;
      end
    end else if (valid) begin
      m_active[i] = 1;
      m_k[i]      = 1;
      m_drv[i]    = (op != 2'b00);
      case (op)
        2'b00:   m_val[i] = q;
        2'b01:   m_val[i] = 1'b1;
        2'b10:   m_val[i] = 1'b0;
        default: m_val[i] = ~q;
      endcase
    end
  endtask

  task automatic check_outputs(input int i);
    bit drive;
    drive = (m_active[i] != 0) && m_drv[i] && (m_k[i] <= hold_of(i));
    check($sformatf("s[%0d]", i),      32'(s_o[i]),    32'(drive && m_val[i]));
    check($sformatf("r[%0d]", i),      32'(r_o[i]),    32'(drive && !m_val[i]));
    check($sformatf("s_and_r[%0d]", i), 32'(s_o[i] & r_o[i]), 32'd0);
    check($sformatf("done[%0d]", i),   32'(done_o[i]),
          32'((m_active[i] != 0) && (m_k[i] == len_of(i))));
    check($sformatf("busy[%0d]", i),   32'(busy_o[i]), 32'(m_active[i] != 0));
    check($sformatf("err[%0d]", i),    32'(err_o[i]),  32'(m_err[i]));
    check($sformatf("cnt[%0d]", i),    32'(cnt_o[i]),  32'(m_cnt[i]));
  endtask

  task automatic step(input bit rst, input bit valid, input logic [1:0] op);
    bit s_prev[2];
    bit r_prev[2];
    RST       = rst;
    CMD_VALID = valid;
    CMD_OP    = op;
    for (int i = 0; i < 2; i++) qfb[i] = stuck_en ? stuck_val : q_lat[i];
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready[%0d]", i), 32'(rdy_o[i]), 32'((m_active[i] == 0) && !rst));
      s_prev[i] = s_o[i];
      r_prev[i] = r_o[i];
    end
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      model_edge(i, rst, valid, op, qfb[i]);
      if (s_prev[i])      q_lat[i] = 1'b1;
      else if (r_prev[i]) q_lat[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    bit done_300;
    RST       = 1'b1;
    CMD_VALID = 1'b0;
    CMD_OP    = 2'b00;
    stuck_en  = 1'b0;
    stuck_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      qfb[i] = 1'b0; q_lat[i] = 1'b0;
      m_active[i] = 0; m_k[i] = 0; m_val[i] = 1'b0; m_drv[i] = 1'b0;
      m_err[i] = 1'b0; m_cnt[i] = 0; m_total[i] = 0;
    end
    repeat (2) @(posedge CLK);
    #1;
    step(1'b1, 1'b1, 2'b01);      // reset wins over a simultaneous command

    // Set, then toggle with Q=1, then hold
    step(1'b0, 1'b1, 2'b01); idle(6);
    step(1'b0, 1'b1, 2'b11); idle(6);
    step(1'b0, 1'b1, 2'b00); idle(2);

    // Reset op with Q stuck at 1: error is sticky through good commands
    stuck_en = 1'b1; stuck_val = 1'b1;
    step(1'b0, 1'b1, 2'b10); idle(6);
    stuck_en = 1'b0;
    step(1'b0, 1'b1, 2'b01); idle(6);
    step(1'b0, 1'b1, 2'b00); idle(2);
    step(1'b1, 1'b0, 2'b00);

    // Reset during the first drive cycle aborts the command
    step(1'b0, 1'b1, 2'b01);
    step(1'b1, 1'b0, 2'b00);
    idle(6);

    // CMD_VALID held high, varying ops, until instance 0 completes 300 commands
    step(1'b1, 1'b0, 2'b00);
    m_total[0] = 0;
    done_300   = 1'b0;
    for (int c = 0; c < 4000 && !done_300; c++) begin
      step(1'b0, 1'b1, 2'(c % 4));
      if (m_total[0] >= 300) done_300 = 1'b1;
    end
    check("wrap_reached", 32'(done_300), 32'd1);
    check("cnt_wrap_44", 32'(cnt_o[0]), 32'd44);

    // Random traffic with occasional reset and feedback faults
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 29) == 0) begin
        stuck_en  = ~stuck_en;
        stuck_val = 1'($urandom_range(0, 1));
      end
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_cmd_driver.md
SR_CMD_DRIVER -- requirements
Module: sr_cmd_driver

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 2: cycles S or R is held high per command (legal range 1..15).
REQ-002 The block SHALL have parameter SETTLE_CYC, default 2: cycles S and R are both low after a pulse before feedback check (legal range 1..15).
REQ-003 The block SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port CMD_VALID  input  1  command request.
REQ-006 The block SHALL have port CMD_OP  input  2  00 hold, 01 set, 10 reset, 11 toggle.
REQ-007 The block SHALL have port CMD_READY  output  1  high when a command can be accepted.
REQ-008 The block SHALL have port Q_FB  input  1  Q fed back from the downstream master-slave SR latch.
REQ-009 The block SHALL have port S  output  1  set drive to latch, registered.
REQ-010 The block SHALL have port R  output  1  reset drive to latch, registered.
REQ-011 The block SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-012 The block SHALL have port DONE  output  1  one-cycle completion pulse, registered.
REQ-013 The block SHALL have port ERR  output  1  sticky feedback-mismatch flag.
REQ-014 The block SHALL have port CMD_CNT  output  8  count of completed commands.

Function
REQ-015 The block SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK; IDLE->DRIVE on accept of op 01/10/11; IDLE->CHECK on accept of op 00; DRIVE->SETTLE after HOLD_CYC cycles; SETTLE->CHECK after SETTLE_CYC cycles; CHECK->IDLE unconditionally.
REQ-016 CMD_READY SHALL be combinational, equal to (state==IDLE && !RST); accept occurs on a rising edge with CMD_VALID && CMD_READY.
REQ-017 On accept the block SHALL latch CMD_OP and the expected value: set->1, reset->0, toggle->~Q_FB sampled at that edge, hold->Q_FB sampled at that edge.
REQ-018 In DRIVE, S SHALL be 1 and R 0 when expected value is 1; R SHALL be 1 and S 0 when expected value is 0; S and R SHALL be 0 in every other state.
REQ-019 S and R SHALL never be 1 in the same cycle, under any input sequence including reset.
REQ-020 In CHECK, DONE SHALL be 1 for exactly one cycle; if Q_FB != expected value, ERR SHALL be set to 1 in the following cycle and hold until RST.
REQ-021 DONE SHALL be asserted HOLD_CYC+SETTLE_CYC+1 cycles after the accept edge for ops 01/10/11, and 1 cycle after for op 00.
REQ-022 CMD_CNT SHALL increment by 1 on each CHECK cycle, wrapping 255->0 without flagging.
REQ-023 CMD_VALID and CMD_OP SHALL be ignored while not in IDLE; no queuing.
REQ-024 A new command SHALL be acceptable in the cycle after CHECK (back-to-back gap of zero idle cycles beyond the IDLE cycle).

Reset
REQ-025 While RST is high at a rising edge the block SHALL go to IDLE, with S=0, R=0, DONE=0, ERR=0, CMD_CNT=0 after that edge.
REQ-026 RST asserted mid-DRIVE SHALL drop S/R to 0 at that edge; the aborted command SHALL NOT produce DONE nor increment CMD_CNT.
REQ-027 RST asserted in the same cycle as CMD_VALID SHALL take priority; the command is not accepted.

Verification
REQ-028 Defaults, Q_FB follows S/R one cycle after each pulse; set op accepted at cycle 0 -> S=1 cycles 1-2, S=R=0 cycles 3-4, DONE=1 cycle 5, ERR=0, CMD_CNT=1.
REQ-029 Q_FB=1, toggle op -> R=1 for 2 cycles, S stays 0, DONE after 5 cycles; then hold op -> no S/R pulse, DONE 1 cycle after accept, CMD_CNT=2.
REQ-030 Reset op with Q_FB stuck at 1 -> DONE at cycle 5, ERR=1 from cycle 6 onward through further good commands, cleared only by RST.
REQ-031 RST pulsed during cycle 1 of a set command -> S=0 next edge, no DONE, CMD_CNT=0, CMD_READY=1 after RST deasserts.
REQ-032 CMD_VALID held high with alternating ops for 300 commands -> CMD_CNT wraps to 44, S&R never both 1 (assertion checked every cycle), CMD_READY low while BUSY.
REQ-033 HOLD_CYC=1, SETTLE_CYC=1 instance -> set command gives S=1 for exactly 1 cycle and DONE at cycle 3.
